program_fetch: RTL and testbench
================================

# program_fetch

Fetch controller that sits directly downstream of the 12-bit program counter with load. It presents the counter value as a ROM address, captures the returned byte one cycle later, and splits it into an instruction nibble and an operand nibble. It hands the pair to the decode stage over a valid/ready handshake, and pulses the counter's enable only when a byte has been captured.

## Interface
- ADDR_W, 12, program counter / ROM address width
- DATA_W, 8, ROM word width; instr = upper DATA_W/2 bits, oprnd = lower DATA_W/2 bits

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep fetching, 0 = finish current item then idle
- flush  in  1  synchronous; discards in-flight/held item (asserted alongside counter load)
- pc  in  ADDR_W  current counter value
- pc_en  out  1  one-cycle pulse to counter enable
- rom_addr  out  ADDR_W  ROM address, combinationally equal to pc
- rom_re  out  1  ROM read strobe (synchronous ROM, data valid next cycle)
- rom_data  in  DATA_W  ROM read data
- out_valid  out  1  instr/oprnd/fetch_pc valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- instr  out  DATA_W/2  rom_data[DATA_W-1:DATA_W/2], registered
- oprnd  out  DATA_W/2  rom_data[DATA_W/2-1:0], registered
- fetch_pc  out  ADDR_W  address the held byte came from
- halted  out  1  wrap-halt indicator (see Configuration)

## Operation
- States: IDLE, ISSUE, CAPTURE, HOLD, and HALT (HALT only with the macro).
- IDLE: every output low. run=1 moves to ISSUE.
- ISSUE: rom_re=1. fetch_pc <= pc. Next state CAPTURE.
- CAPTURE: rom_data is valid. At the edge: instr/oprnd <= split of rom_data, out_valid <= 1, next state HOLD. pc_en=1, combinational, this cycle only.
- HOLD: out_valid=1. instr, oprnd and fetch_pc are stable. rom_re=0 and pc_en=0.
  - out_ready=0: stay in HOLD.
  - out_ready=1: transfer, out_valid <= 0. Next state is ISSUE if run=1, else IDLE.
- Dropping run mid-item never aborts the item. It completes through HOLD/transfer, then goes to IDLE.
- flush=1 at any edge:
  - state <= IDLE, out_valid <= 0.
  - pc_en and rom_re are forced 0 combinationally in that cycle, so the counter is not advanced by a flushed fetch.
  - flush beats run, out_ready and CAPTURE.
- The counter owns wrap-around (0xFFF -> 0x000). Without the macro, this block does not special-case it.
- Widths: no arithmetic inside the block. All buses pass straight through or are register copies.

## Timing
- Reset (reset=0, asynchronous): state IDLE. out_valid, pc_en, rom_re, halted, instr, oprnd and fetch_pc all = 0. rom_addr follows pc.
- Latency: run rises in cycle 0 (state IDLE). ISSUE in cycle 1, CAPTURE in cycle 2, out_valid=1 from cycle 3.
- pc_en is high exactly in cycle 2. The counter shows pc+1 from cycle 3.
- Throughput with out_ready held at 1: one item every 3 cycles (ISSUE, CAPTURE, HOLD).
- rom_re is never high in two consecutive cycles.
- pc_en is high at most once per item.
- Reset released mid-stream: restart from IDLE. No stale out_valid.

## Configuration
- Macro: FETCH_WRAP_HALT_EN.
- Defined:
  - In CAPTURE with fetch_pc == all-ones (0xFFF), pc_en is suppressed.
  - After that item transfers, the FSM enters HALT: halted=1, rom_re=0, pc_en=0, out_valid=0.
  - HALT is left only by reset. flush and run are ignored in HALT.
- Undefined: no HALT state. halted is tied to 0. Address 0xFFF is fetched like any other, pc_en pulses, and the counter wraps to 0x000.

## Test plan
- Reset: assert reset=0 mid-HOLD with out_valid=1 -> all outputs 0 immediately, without waiting for clk. After release, no out_valid until run=1.
- Single fetch: pc=0x005, ROM[0x005]=0xA3, run=1, out_ready=1 -> cycle 1 rom_re=1, cycle 2 pc_en=1, cycle 3 out_valid=1 with instr=0xA, oprnd=0x3, fetch_pc=0x005. Counter then reads 0x006.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> instr, oprnd and fetch_pc stable. pc_en=0 and rom_re=0 throughout. One transfer when out_ready=1.
- Flush in CAPTURE: flush=1 in cycle 2 -> pc_en=0 that cycle, no out_valid, state IDLE. Counter unchanged at 0x005.
- Wrap: pc=0xFFF, ROM=0x7E, continuous run.
  - Without macro: item 0x7/0xE, pc_en pulses, next fetch_pc=0x000.
  - With FETCH_WRAP_HALT_EN: pc_en not pulsed. After transfer, halted=1 and no further rom_re until reset.
- run drop: run=0 during CAPTURE -> item still delivered and transferred, then IDLE. No further rom_re.

Source files
------------

// File: rtl/program_fetch.sv
// Fetch controller between the program counter and a synchronous ROM; splits each byte
// into instr/oprnd nibbles for decode. Optional wrap-halt at the top address: FETCH_WRAP_HALT_EN.
//
// state   | meaning
// IDLE    | nothing in flight, all strobes low
// ISSUE   | rom_re high, fetch_pc captured from pc
// CAPTURE | rom_data valid, counter advanced via pc_en
// HOLD    | item presented, waiting for out_ready
// HALT    | wrap-halt reached (FETCH_WRAP_HALT_EN only), left only by reset
module program_fetch #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   pc,
   output logic                pc_en,
   output logic [ADDR_W-1:0]   rom_addr,
   output logic                rom_re,
   input  logic [DATA_W-1:0]   rom_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W/2-1:0] instr,
   output logic [DATA_W/2-1:0] oprnd,
   output logic [ADDR_W-1:0]   fetch_pc,
   output logic                halted
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
`ifdef FETCH_WRAP_HALT_EN
   localparam logic [2:0] HALT    = 3'd4;
`endif

   logic [2:0] state, state_nxt;
   logic       flush_eff;
   logic       wrap_stop;

`ifdef FETCH_WRAP_HALT_EN
   // Halt is sticky: flush cannot pull the FSM out of it.
   assign flush_eff = flush & (state != HALT);
   assign wrap_stop = &fetch_pc;
   assign halted    = (state == HALT);
`else
   assign flush_eff = flush;
   assign wrap_stop = 1'b0;
   assign halted    = 1'b0;
`endif

   assign rom_addr = pc;
   assign rom_re   = (state == ISSUE) & ~flush_eff;
   assign pc_en    = (state == CAPTURE) & ~flush_eff & ~wrap_stop;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run) state_nxt = ISSUE;
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = HOLD;
         HOLD: begin
            if (out_ready) begin
`ifdef FETCH_WRAP_HALT_EN
               if (wrap_stop)
                  state_nxt = HALT;
               else
                  state_nxt = run ? ISSUE : IDLE;
`else
               state_nxt = run ? ISSUE : IDLE;
`endif
            end
         end
`ifdef FETCH_WRAP_HALT_EN
         HALT:    state_nxt = HALT;
`endif
         default: state_nxt = IDLE;
      endcase
      if (flush_eff) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         instr     <= '0;
         oprnd     <= '0;
         fetch_pc  <= '0;
      end else begin
         state <= state_nxt;
         if (flush_eff) begin
            out_valid <= 1'b0;
         end else begin
            if (state == ISSUE)
               fetch_pc <= pc;
            if (state == CAPTURE) begin
               instr     <= rom_data[DATA_W-1:DATA_W/2];
               oprnd     <= rom_data[DATA_W/2-1:0];
               out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready)
               out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: program counter + synchronous ROM around the DUT, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_program_fetch;

`ifdef FETCH_WRAP_HALT_EN
   localparam bit HALT_BUILD = 1'b1;
`else
   localparam bit HALT_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        flush = 1'b0;
   logic [11:0] pc = '0;
   logic        pc_en;
   logic [11:0] rom_addr;
   logic        rom_re;
   logic [7:0]  rom_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  instr;
   logic [3:0]  oprnd;
   logic [11:0] fetch_pc;
   logic        halted;

   logic        ld = 1'b0;
   logic [11:0] ld_val = '0;
   logic [7:0]  rom [4096];

   int errors = 0;
   int checks = 0;
   int xfers  = 0;

   // reference model: item phase 0 idle, 1 address out, 2 data back, 3 presented, 4 halted
   int          m_phase = 0;
   logic [11:0] m_fpc = '0;
   logic [3:0]  m_instr = '0;
   logic [3:0]  m_oprnd = '0;
   logic        m_valid = 1'b0;
   int          m_xfers = 0;

   program_fetch dut (
      .clk(clk), .reset(reset), .run(run), .flush(flush), .pc(pc),
      .pc_en(pc_en), .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .oprnd(oprnd),
      .fetch_pc(fetch_pc), .halted(halted)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld) pc <= ld_val;
      else if (pc_en) pc <= pc + 12'd1;
      rom_data <= rom[rom_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0; m_valid <= 1'b0; m_fpc <= '0; m_instr <= '0; m_oprnd <= '0;
      end else if (flush && !(HALT_BUILD && m_phase == 4)) begin
         m_phase <= 0; m_valid <= 1'b0;
      end else begin
         case (m_phase)
            0: if (run) m_phase <= 1;
            1: begin m_fpc <= pc; m_phase <= 2; end
            2: begin
               m_instr <= 4'(rom[m_fpc] / 16);
               m_oprnd <= 4'(rom[m_fpc] % 16);
               m_valid <= 1'b1;
               m_phase <= 3;
            end
            3: if (out_ready) begin
               m_valid <= 1'b0;
               m_xfers <= m_xfers + 1;
               m_phase <= (HALT_BUILD && m_fpc == 12'hFFF) ? 4 : (run ? 1 : 0);
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("rom_addr", 32'(rom_addr), 32'(pc));
      chk("rom_re", 32'(rom_re), 32'(reset && m_phase == 1 && !flush));
      chk("pc_en", 32'(pc_en),
          32'(reset && m_phase == 2 && !flush && !(HALT_BUILD && m_fpc == 12'hFFF)));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_phase == 4));
      if (m_valid || !reset) begin
         chk("instr", 32'(instr), 32'(m_instr));
         chk("oprnd", 32'(oprnd), 32'(m_oprnd));
         chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
      end
      if (out_valid && out_ready) xfers++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [11:0] v);
      ld = 1'b1; ld_val = v;
      tick();
      ld = 1'b0;
   endtask

   initial begin
      int x0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 37 + 5);
      rom[12'h005] = 8'hA3;
      rom[12'h020] = 8'h5C;
      rom[12'hFFF] = 8'h7E;
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_fetch_pc", 32'(fetch_pc), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      reset = 1'b1;
      tick();

      // single fetch, run dropped during CAPTURE
      load(12'h005);
      run = 1'b1;
      tick();
      chk("c1_rom_re", 32'(rom_re), 32'd1);
      chk("c1_pc_en", 32'(pc_en), 32'd0);
      tick();
      chk("c2_pc_en", 32'(pc_en), 32'd1);
      chk("c2_rom_re", 32'(rom_re), 32'd0);
      run = 1'b0;
      tick();
      chk("c3_valid", 32'(out_valid), 32'd1);
      chk("c3_instr", 32'(instr), 32'hA);
      chk("c3_oprnd", 32'(oprnd), 32'h3);
      chk("c3_fetch_pc", 32'(fetch_pc), 32'h005);
      chk("c3_pc", 32'(pc), 32'h006);
      tick();
      chk("after_xfer_valid", 32'(out_valid), 32'd0);
      repeat (4) tick();
      chk("rundrop_rom_re", 32'(rom_re), 32'd0);
      chk("rundrop_pc", 32'(pc), 32'h006);

      // backpressure
      load(12'h020);
      out_ready = 1'b0;
      run = 1'b1;
      repeat (3) tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      run = 1'b0;
      x0 = xfers;
      repeat (5) begin
         tick();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_instr", 32'(instr), 32'h5);
         chk("bp_oprnd", 32'(oprnd), 32'hC);
         chk("bp_fetch_pc", 32'(fetch_pc), 32'h020);
         chk("bp_rom_re", 32'(rom_re), 32'd0);
         chk("bp_pc_en", 32'(pc_en), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_after_valid", 32'(out_valid), 32'd0);
      chk("bp_one_xfer", 32'(xfers - x0), 32'd1);
      chk("bp_pc", 32'(pc), 32'h021);

      // flush during CAPTURE, issued alongside a counter load
      flush = 1'b1;
      load(12'h005);
      flush = 1'b0;
      run = 1'b1;
      tick();
      tick();
      flush = 1'b1;
      run = 1'b0;
      #1;
      chk("flush_pc_en", 32'(pc_en), 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_pc", 32'(pc), 32'h005);
      repeat (3) tick();
      chk("flush_idle_rom_re", 32'(rom_re), 32'd0);
      chk("flush_idle_valid", 32'(out_valid), 32'd0);

      // wrap at the top address
      load(12'hFFF);
      run = 1'b1;
      tick();
      tick();
      chk("wrap_pc_en", 32'(pc_en), HALT_BUILD ? 32'd0 : 32'd1);
      tick();
      chk("wrap_valid", 32'(out_valid), 32'd1);
      chk("wrap_instr", 32'(instr), 32'h7);
      chk("wrap_oprnd", 32'(oprnd), 32'hE);
      chk("wrap_fetch_pc", 32'(fetch_pc), 32'hFFF);
      chk("wrap_pc", 32'(pc), HALT_BUILD ? 32'hFFF : 32'h000);
`ifdef FETCH_WRAP_HALT_EN
      tick();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_valid", 32'(out_valid), 32'd0);
      flush = 1'b1;
      repeat (4) tick();
      flush = 1'b0;
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_rom_re", 32'(rom_re), 32'd0);
      run = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("halt_cleared", 32'(halted), 32'd0);
`else
      repeat (3) tick();
      chk("wrap_next_fetch_pc", 32'(fetch_pc), 32'h000);
      chk("wrap_next_instr", 32'(instr), 32'h0);
      chk("wrap_next_oprnd", 32'(oprnd), 32'h5);
      run = 1'b0;
      tick();
`endif
      repeat (2) tick();

      // asynchronous reset while an item is held
      load(12'h005);
      out_ready = 1'b0;
      run = 1'b1;
      repeat (3) tick();
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid), 32'd0);
      chk("rst_async_instr", 32'(instr), 32'd0);
      chk("rst_async_oprnd", 32'(oprnd), 32'd0);
      chk("rst_async_fetch_pc", 32'(fetch_pc), 32'd0);
      chk("rst_async_rom_re", 32'(rom_re) | 32'(pc_en), 32'd0);
      run = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_release_valid", 32'(out_valid), 32'd0);
      chk("rst_release_rom_re", 32'(rom_re), 32'd0);

      // streaming with irregular backpressure
      load(12'h100);
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         out_ready = ((i % 5) != 1) && ((i % 7) != 3);
         tick();
      end
      run = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && (m_phase != 0 || out_valid); i++) tick();
      chk("stream_drained", 32'(out_valid) | 32'(m_phase != 0), 32'd0);
      chk("stream_xfers", 32'(xfers), 32'(m_xfers));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
